// File: rtl/ddr3_dma_pkg.sv
// Shared definitions for the DDR3 DMA command path: descriptor layout,
// command codes and the executor state encoding.
package ddr3_dma_pkg;

  localparam int DESC_W        = 39;
  localparam int DESC_ADDR_LSB = 0;
  localparam int DESC_ADDR_MSB = 27;
  localparam int DESC_BL_LSB   = 28;
  localparam int DESC_BL_MSB   = 35;
  localparam int DESC_CMD_LSB  = 36;
  localparam int DESC_CMD_MSB  = 38;

  localparam logic [2:0] WR_CMD_CODE = 3'd0;
  localparam logic [2:0] RD_CMD_CODE = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WR,
    ST_LOAD_RD,
    ST_WR_BURST,
    ST_RD_BURST,
    ST_RD_WAIT
  } exec_state_t;

  // A burst-length field of zero encodes the maximum burst of 256 beats.
  function automatic logic [8:0] bl_to_beats(input logic [7:0] bl);
    return (bl == 8'd0) ? 9'd256 : {1'b0, bl};
  endfunction

endpackage

// File: rtl/ddr3_rr_arb.sv
// Two-way round-robin grant between the write and read command FIFOs.
// The pointer flips on every grant so contending sources alternate.
module ddr3_rr_arb (
  input  logic I_Clk,
  input  logic I_Rst_n,
  input  logic I_En,
  input  logic I_Req_Wr,
  input  logic I_Req_Rd,
  output logic O_Gnt_Wr,
  output logic O_Gnt_Rd
);

  logic ptr_rd;

  always_comb begin
    O_Gnt_Wr = I_En & I_Req_Wr & (~I_Req_Rd | ~ptr_rd);
    O_Gnt_Rd = I_En & I_Req_Rd & (~I_Req_Wr | ptr_rd);
  end

  always_ff @(posedge I_Clk) begin
    if (!I_Rst_n) begin
      ptr_rd <= 1'b0;
    end else if (O_Gnt_Wr | O_Gnt_Rd) begin
      ptr_rd <= ~ptr_rd;
    end
  end

endmodule

// File: rtl/ddr3_cmd_executor.sv
// Executes DMA write/read descriptors on the MIG native app interface:
// streams write beats from the data FIFO and returns read beats to the read FIFO.
module ddr3_cmd_executor
  import ddr3_dma_pkg::*;
#(
  parameter int         ADDR_W    = 28,
  parameter int         DATA_W    = 256,
  parameter int         ADDR_STEP = 8,
  parameter logic [2:0] WR_CMD    = WR_CMD_CODE,
  parameter logic [2:0] RD_CMD    = RD_CMD_CODE
) (
  input  logic                I_Clk,
  input  logic                I_Rst_n,
  input  logic                I_Init_Done,
  input  logic                I_Wr_Cmd_Empty,
  input  logic [DESC_W-1:0]   I_Wr_Cmd_Data,
  output logic                O_Wr_Cmd_Rden,
  input  logic                I_Rd_Cmd_Empty,
  input  logic [DESC_W-1:0]   I_Rd_Cmd_Data,
  output logic                O_Rd_Cmd_Rden,
  input  logic                I_Wr_Data_Empty,
  input  logic [DATA_W-1:0]   I_Wr_Data,
  output logic                O_Wr_Data_Rden,
  input  logic                I_Rd_Fifo_Afull,
  output logic                O_Rd_Data_Wren,
  output logic [DATA_W-1:0]   O_Rd_Data,
  output logic                O_App_En,
  output logic [2:0]          O_App_Cmd,
  output logic [ADDR_W-1:0]   O_App_Addr,
  input  logic                I_App_Rdy,
  output logic                O_App_Wdf_Wren,
  output logic                O_App_Wdf_End,
  output logic [DATA_W-1:0]   O_App_Wdf_Data,
  output logic [DATA_W/8-1:0] O_App_Wdf_Mask,
  input  logic                I_App_Wdf_Rdy,
  input  logic [DATA_W-1:0]   I_App_Rd_Data,
  input  logic                I_App_Rd_Data_Valid,
  output logic                O_Busy,
  output logic                O_Cmd_Err
);

  exec_state_t         state;
  logic [ADDR_W-1:0]   base_addr;
  logic [2:0]          cmd_code;
  logic [8:0]          beats;
  logic [8:0]          cmd_cnt;
  logic [8:0]          dat_cnt;
  logic [8:0]          ret_cnt;
  logic                gnt_wr;
  logic                gnt_rd;
  logic [DESC_W-1:0]   desc_sel;
  logic                app_en;
  logic [2:0]          app_cmd;
  logic                app_acc;
  logic                wdf_wren;
  logic                wdf_acc;
  logic [ADDR_W-1:0]   app_addr;
  logic                vld_p1;
  logic [DATA_W-1:0]   rd_data_p1;

  ddr3_rr_arb u_arb (
    .I_Clk    (I_Clk),
    .I_Rst_n  (I_Rst_n),
    .I_En     ((state == ST_IDLE) & I_Init_Done),
    .I_Req_Wr (~I_Wr_Cmd_Empty),
    .I_Req_Rd (~I_Rd_Cmd_Empty),
    .O_Gnt_Wr (gnt_wr),
    .O_Gnt_Rd (gnt_rd)
  );

  assign desc_sel = gnt_wr ? I_Wr_Cmd_Data : I_Rd_Cmd_Data;

  always_comb begin
    app_en  = 1'b0;
    app_cmd = 3'd0;
    case (state)
      ST_WR_BURST: begin
        app_en  = (cmd_cnt < beats);
        app_cmd = WR_CMD;
      end
      ST_RD_BURST: begin
        app_en  = (cmd_cnt < beats) & ~I_Rd_Fifo_Afull;
        app_cmd = RD_CMD;
      end
      default: begin
        app_en  = 1'b0;
        app_cmd = 3'd0;
      end
    endcase
  end

  // Address follows the accepted-command count, so it holds whenever App_En is paused.
  assign app_addr = base_addr + ADDR_W'(cmd_cnt) * ADDR_W'(ADDR_STEP);
  assign wdf_wren = (state == ST_WR_BURST) & ~I_Wr_Data_Empty & (dat_cnt < beats);
  assign app_acc  = app_en & I_App_Rdy;
  assign wdf_acc  = wdf_wren & I_App_Wdf_Rdy;

  assign O_Wr_Cmd_Rden  = gnt_wr;
  assign O_Rd_Cmd_Rden  = gnt_rd;
  assign O_App_En       = app_en;
  assign O_App_Cmd      = app_cmd;
  assign O_App_Addr     = ((state == ST_WR_BURST) || (state == ST_RD_BURST)) ? app_addr : '0;
  assign O_App_Wdf_Wren = wdf_wren;
  assign O_App_Wdf_End  = wdf_wren;
  assign O_App_Wdf_Data = wdf_wren ? I_Wr_Data : '0;
  assign O_App_Wdf_Mask = '0;
  assign O_Wr_Data_Rden = wdf_acc;
  assign O_Busy         = (state != ST_IDLE);
  assign O_Rd_Data_Wren = vld_p1;
  assign O_Rd_Data      = rd_data_p1;

  always_ff @(posedge I_Clk) begin
    if (!I_Rst_n) begin
      state      <= ST_IDLE;
      base_addr  <= '0;
      cmd_code   <= 3'd0;
      beats      <= 9'd0;
      cmd_cnt    <= 9'd0;
      dat_cnt    <= 9'd0;
      ret_cnt    <= 9'd0;
      O_Cmd_Err  <= 1'b0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      O_Cmd_Err <= 1'b0;
      // Return stage p1: read path is always open, including protocol-error beats outside reads.
      vld_p1     <= I_App_Rd_Data_Valid;
      rd_data_p1 <= I_App_Rd_Data;
      if (((state == ST_RD_BURST) || (state == ST_RD_WAIT)) && I_App_Rd_Data_Valid) begin
        ret_cnt <= ret_cnt + 9'd1;
      end

      case (state)
        ST_IDLE: begin
          if (gnt_wr || gnt_rd) begin
            base_addr <= ADDR_W'(desc_sel[DESC_ADDR_MSB:DESC_ADDR_LSB]);
            beats     <= bl_to_beats(desc_sel[DESC_BL_MSB:DESC_BL_LSB]);
            cmd_code  <= desc_sel[DESC_CMD_MSB:DESC_CMD_LSB];
            cmd_cnt   <= 9'd0;
            dat_cnt   <= 9'd0;
            ret_cnt   <= 9'd0;
            state     <= gnt_wr ? ST_LOAD_WR : ST_LOAD_RD;
          end
        end
        ST_LOAD_WR: begin
          if (cmd_code == WR_CMD) begin
            state <= ST_WR_BURST;
          end else begin
            O_Cmd_Err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_LOAD_RD: begin
          if (cmd_code == RD_CMD) begin
            state <= ST_RD_BURST;
          end else begin
            O_Cmd_Err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WR_BURST: begin
          if (app_acc) cmd_cnt <= cmd_cnt + 9'd1;
          if (wdf_acc) dat_cnt <= dat_cnt + 9'd1;
          if ((cmd_cnt == beats) && (dat_cnt == beats)) state <= ST_IDLE;
        end
        ST_RD_BURST: begin
          if (app_acc) cmd_cnt <= cmd_cnt + 9'd1;
          if (cmd_cnt == beats) state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (ret_cnt == beats) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_executor.sv
// Scoreboard bench for ddr3_cmd_executor: FIFO and MIG models around the DUT,
// expected grants/app commands/beats queued at stimulus time and popped on DUT output.
module tb_ddr3_cmd_executor;
  import ddr3_dma_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;

  logic                I_Clk = 1'b0;
  logic                I_Rst_n, I_Init_Done;
  logic                I_Wr_Cmd_Empty, I_Rd_Cmd_Empty, I_Wr_Data_Empty;
  logic [DESC_W-1:0]   I_Wr_Cmd_Data, I_Rd_Cmd_Data;
  logic [DATA_W-1:0]   I_Wr_Data, I_App_Rd_Data;
  logic                I_Rd_Fifo_Afull, I_App_Rdy, I_App_Wdf_Rdy, I_App_Rd_Data_Valid;
  logic                O_Wr_Cmd_Rden, O_Rd_Cmd_Rden, O_Wr_Data_Rden, O_Rd_Data_Wren;
  logic [DATA_W-1:0]   O_Rd_Data, O_App_Wdf_Data;
  logic                O_App_En, O_App_Wdf_Wren, O_App_Wdf_End, O_Busy, O_Cmd_Err;
  logic [2:0]          O_App_Cmd;
  logic [ADDR_W-1:0]   O_App_Addr;
  logic [DATA_W/8-1:0] O_App_Wdf_Mask;

  always #5 I_Clk = ~I_Clk;

  ddr3_cmd_executor dut (
    .I_Clk(I_Clk), .I_Rst_n(I_Rst_n), .I_Init_Done(I_Init_Done),
    .I_Wr_Cmd_Empty(I_Wr_Cmd_Empty), .I_Wr_Cmd_Data(I_Wr_Cmd_Data), .O_Wr_Cmd_Rden(O_Wr_Cmd_Rden),
    .I_Rd_Cmd_Empty(I_Rd_Cmd_Empty), .I_Rd_Cmd_Data(I_Rd_Cmd_Data), .O_Rd_Cmd_Rden(O_Rd_Cmd_Rden),
    .I_Wr_Data_Empty(I_Wr_Data_Empty), .I_Wr_Data(I_Wr_Data), .O_Wr_Data_Rden(O_Wr_Data_Rden),
    .I_Rd_Fifo_Afull(I_Rd_Fifo_Afull), .O_Rd_Data_Wren(O_Rd_Data_Wren), .O_Rd_Data(O_Rd_Data),
    .O_App_En(O_App_En), .O_App_Cmd(O_App_Cmd), .O_App_Addr(O_App_Addr), .I_App_Rdy(I_App_Rdy),
    .O_App_Wdf_Wren(O_App_Wdf_Wren), .O_App_Wdf_End(O_App_Wdf_End), .O_App_Wdf_Data(O_App_Wdf_Data),
    .O_App_Wdf_Mask(O_App_Wdf_Mask), .I_App_Wdf_Rdy(I_App_Wdf_Rdy),
    .I_App_Rd_Data(I_App_Rd_Data), .I_App_Rd_Data_Valid(I_App_Rd_Data_Valid),
    .O_Busy(O_Busy), .O_Cmd_Err(O_Cmd_Err)
  );

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } app_t;

  logic [DESC_W-1:0] wr_cmd_q[$];
  logic [DESC_W-1:0] rd_cmd_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [DATA_W-1:0] exp_wdf[$];
  logic [DATA_W-1:0] exp_rd[$];
  app_t              exp_app[$];
  bit                exp_gnt[$];
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_time[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int app_acc_cnt = 0, wd_pop_cnt = 0, rd_ret_cnt = 0, err_pulses = 0;
  bit rdy_tog = 1'b0, wdf_tog = 1'b0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
    return {8{4'hA, a}};
  endfunction

  function automatic logic [13:0] out_vec();
    return {O_Wr_Cmd_Rden, O_Rd_Cmd_Rden, O_Wr_Data_Rden, O_Rd_Data_Wren, O_App_En,
            O_App_Wdf_Wren, O_App_Wdf_End, O_Busy, O_Cmd_Err, |O_App_Cmd, |O_App_Addr,
            |O_Rd_Data, |O_App_Wdf_Data, |O_App_Wdf_Mask};
  endfunction

  task automatic push_wr(input logic [2:0] c, input logic [7:0] bl, input logic [ADDR_W-1:0] base,
                         input logic [DATA_W-1:0] dbase, input bit good);
    int n;
    app_t e;
    n = (bl == 8'd0) ? 256 : int'(bl);
    wr_cmd_q.push_back({c, bl, base});
    exp_gnt.push_back(1'b0);
    if (good) begin
      for (int i = 0; i < n; i++) begin
        e.cmd  = WR_CMD_CODE;
        e.addr = base + ADDR_W'(i * 8);
        exp_app.push_back(e);
        wd_q.push_back(dbase + DATA_W'(i));
        exp_wdf.push_back(dbase + DATA_W'(i));
      end
    end
  endtask

  task automatic push_rd(input logic [7:0] bl, input logic [ADDR_W-1:0] base);
    int n;
    app_t e;
    n = (bl == 8'd0) ? 256 : int'(bl);
    rd_cmd_q.push_back({RD_CMD_CODE, bl, base});
    exp_gnt.push_back(1'b1);
    for (int i = 0; i < n; i++) begin
      e.cmd  = RD_CMD_CODE;
      e.addr = base + ADDR_W'(i * 8);
      exp_app.push_back(e);
      exp_rd.push_back(rd_pat(e.addr));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge I_Clk); #1;
      if (!O_Busy && !O_Rd_Data_Wren && exp_app.size() == 0 && exp_wdf.size() == 0 &&
          exp_rd.size() == 0 && wr_cmd_q.size() == 0 && rd_cmd_q.size() == 0 &&
          pend_addr.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check({"done_", tag}, done, 1);
  endtask

  // FIFO and MIG models: observe at negedge, update inputs just after posedge.
  initial begin
    bit   pop_wc, pop_rc, pop_wd;
    app_t e;
    I_Wr_Cmd_Empty = 1'b1; I_Wr_Cmd_Data = '0;
    I_Rd_Cmd_Empty = 1'b1; I_Rd_Cmd_Data = '0;
    I_Wr_Data_Empty = 1'b1; I_Wr_Data = '0;
    I_App_Rdy = 1'b1; I_App_Wdf_Rdy = 1'b1;
    I_App_Rd_Data_Valid = 1'b0; I_App_Rd_Data = '0;
    forever begin
      @(negedge I_Clk);
      pop_wc = O_Wr_Cmd_Rden;
      pop_rc = O_Rd_Cmd_Rden;
      pop_wd = O_Wr_Data_Rden;
      if (O_Wr_Cmd_Rden) begin
        check("wcmd_pop_nonempty", wr_cmd_q.size() != 0, 1);
        if (exp_gnt.size() == 0) check("gnt_unexp_wr", exp_gnt.size(), 1);
        else check("gnt_order_wr", 1'b0, exp_gnt.pop_front());
      end
      if (O_Rd_Cmd_Rden) begin
        check("rcmd_pop_nonempty", rd_cmd_q.size() != 0, 1);
        if (exp_gnt.size() == 0) check("gnt_unexp_rd", exp_gnt.size(), 1);
        else check("gnt_order_rd", 1'b1, exp_gnt.pop_front());
      end
      if (O_App_En && I_App_Rdy) begin
        app_acc_cnt++;
        if (exp_app.size() == 0) begin
          check("app_unexp", exp_app.size(), 1);
        end else begin
          e = exp_app.pop_front();
          check("app_cmd", O_App_Cmd, e.cmd);
          check("app_addr", O_App_Addr, e.addr);
        end
        if (O_App_Cmd == RD_CMD_CODE) begin
          pend_addr.push_back(O_App_Addr);
          pend_time.push_back(cyc + 20);
        end
      end
      if (O_Wr_Data_Rden) wd_pop_cnt++;
      if (O_App_Wdf_Wren && I_App_Wdf_Rdy) begin
        if (exp_wdf.size() == 0) check("wdf_unexp", exp_wdf.size(), 1);
        else check("wdf_data", O_App_Wdf_Data, exp_wdf.pop_front());
        check("wdf_end", O_App_Wdf_End, 1);
        check("wdf_mask", O_App_Wdf_Mask, 0);
        check("wd_rden", O_Wr_Data_Rden, 1);
      end
      if (O_Rd_Data_Wren) begin
        rd_ret_cnt++;
        if (exp_rd.size() == 0) check("rd_unexp", exp_rd.size(), 1);
        else check("rd_data", O_Rd_Data, exp_rd.pop_front());
      end
      if (O_Cmd_Err) err_pulses++;

      @(posedge I_Clk); #1;
      cyc++;
      if (pop_wc && wr_cmd_q.size() > 0) void'(wr_cmd_q.pop_front());
      if (pop_rc && rd_cmd_q.size() > 0) void'(rd_cmd_q.pop_front());
      if (pop_wd && wd_q.size() > 0) void'(wd_q.pop_front());
      I_Wr_Cmd_Empty  = (wr_cmd_q.size() == 0);
      I_Wr_Cmd_Data   = I_Wr_Cmd_Empty ? '0 : wr_cmd_q[0];
      I_Rd_Cmd_Empty  = (rd_cmd_q.size() == 0);
      I_Rd_Cmd_Data   = I_Rd_Cmd_Empty ? '0 : rd_cmd_q[0];
      I_Wr_Data_Empty = (wd_q.size() == 0);
      I_Wr_Data       = I_Wr_Data_Empty ? '0 : wd_q[0];
      I_App_Rdy       = rdy_tog ? ~I_App_Rdy : 1'b1;
      I_App_Wdf_Rdy   = wdf_tog ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend_addr.size() > 0 && pend_time[0] <= cyc) begin
        I_App_Rd_Data_Valid = 1'b1;
        I_App_Rd_Data       = rd_pat(pend_addr.pop_front());
        void'(pend_time.pop_front());
      end else begin
        I_App_Rd_Data_Valid = 1'b0;
        I_App_Rd_Data       = '0;
      end
    end
  end

  initial begin
    int viol, a0, w0, r0, e0;
    bit reached;
    I_Rst_n = 1'b0; I_Init_Done = 1'b0; I_Rd_Fifo_Afull = 1'b0;
    repeat (4) @(posedge I_Clk);
    @(negedge I_Clk); #1;
    check("rst_outs", out_vec(), 0);
    @(posedge I_Clk); #1;
    I_Rst_n = 1'b1;

    // Both FIFOs loaded while calibration is incomplete.
    push_wr(WR_CMD_CODE, 8'd4, 28'h40, 256'h500, 1'b1);
    push_rd(8'd4, 28'h80);
    viol = 0;
    repeat (100) begin
      @(negedge I_Clk); #1;
      if (O_Wr_Cmd_Rden || O_Rd_Cmd_Rden || O_App_En || O_Busy) viol++;
    end
    check("init_hold", viol, 0);
    @(posedge I_Clk); #1;
    I_Init_Done = 1'b1;
    wait_done("init_release", 400);

    // 64-beat write at address 0, data 0..63.
    a0 = app_acc_cnt; w0 = wd_pop_cnt;
    push_wr(WR_CMD_CODE, 8'd64, 28'h0, 256'h0, 1'b1);
    wait_done("wr64", 600);
    check("wr64_app_cnt", app_acc_cnt - a0, 64);
    check("wr64_pops", wd_pop_cnt - w0, 64);

    // 64-beat read with App_Rdy toggling.
    a0 = app_acc_cnt; r0 = rd_ret_cnt;
    rdy_tog = 1'b1;
    push_rd(8'd64, 28'h100);
    wait_done("rd64", 800);
    rdy_tog = 1'b0;
    check("rd64_app_cnt", app_acc_cnt - a0, 64);
    check("rd64_ret_cnt", rd_ret_cnt - r0, 64);

    // Two descriptors in each FIFO: grants alternate W,R,W,R.
    push_wr(WR_CMD_CODE, 8'd2, 28'h400, 256'h700, 1'b1);
    push_rd(8'd2, 28'h500);
    push_wr(WR_CMD_CODE, 8'd2, 28'h600, 256'h800, 1'b1);
    push_rd(8'd2, 28'h700);
    wait_done("rr4", 600);
    check("rr4_gnt_left", exp_gnt.size(), 0);

    // Almost-full held 30 cycles mid read burst.
    a0 = app_acc_cnt;
    push_rd(8'd64, 28'h1000);
    reached = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge I_Clk); #1;
      if (app_acc_cnt - a0 >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    check("afull_reach10", reached, 1);
    @(posedge I_Clk); #1;
    I_Rd_Fifo_Afull = 1'b1;
    viol = 0;
    w0 = app_acc_cnt;
    repeat (30) begin
      @(negedge I_Clk); #1;
      if (O_App_En) viol++;
    end
    check("afull_en_low", viol, 0);
    check("afull_no_acc", app_acc_cnt - w0, 0);
    @(posedge I_Clk); #1;
    I_Rd_Fifo_Afull = 1'b0;
    wait_done("afull_rd", 800);
    check("afull_app_cnt", app_acc_cnt - a0, 64);

    // Bad command code in the write FIFO.
    a0 = app_acc_cnt; e0 = err_pulses;
    push_wr(3'd5, 8'd8, 28'h0, 256'h0, 1'b0);
    repeat (12) @(negedge I_Clk);
    #1;
    check("cmderr_pulses", err_pulses - e0, 1);
    check("cmderr_no_app", app_acc_cnt - a0, 0);
    check("cmderr_idle", O_Busy, 0);
    wait_done("cmderr", 50);

    // bl=0 write at top of address space, with Wdf_Rdy randomly stalling.
    a0 = app_acc_cnt; w0 = wd_pop_cnt;
    wdf_tog = 1'b1;
    push_wr(WR_CMD_CODE, 8'd0, 28'hFFFFFF8, 256'h1000, 1'b1);
    wait_done("wr256_wrap", 3000);
    wdf_tog = 1'b0;
    check("wr256_app_cnt", app_acc_cnt - a0, 256);
    check("wr256_pops", wd_pop_cnt - w0, 256);

    // Reset at beat 10 of a write, then a read runs normally.
    w0 = wd_pop_cnt;
    push_wr(WR_CMD_CODE, 8'd32, 28'h200, 256'h2000, 1'b1);
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge I_Clk); #1;
      if (wd_pop_cnt - w0 >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_reach10", reached, 1);
    @(posedge I_Clk); #1;
    I_Rst_n = 1'b0;
    @(negedge I_Clk);
    @(negedge I_Clk); #1;
    check("rst_mid_outs", out_vec(), 0);
    check("rst_mid_busy", O_Busy, 0);
    wd_q.delete(); exp_wdf.delete(); exp_app.delete(); exp_gnt.delete(); wr_cmd_q.delete();
    @(posedge I_Clk); #1;
    I_Rst_n = 1'b1;
    r0 = rd_ret_cnt;
    push_rd(8'd16, 28'h300);
    wait_done("post_rst_rd", 400);
    check("post_rst_ret", rd_ret_cnt - r0, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
